// File: rtl/cal_pkg.sv
// Shared constants for the calendar date counter: manual field-select
// encoding and month lengths.
package cal_pkg;

    localparam logic [1:0] SEL_DAY   = 2'd0;
    localparam logic [1:0] SEL_MONTH = 2'd1;
    localparam logic [1:0] SEL_YEAR  = 2'd2;
    localparam logic [1:0] SEL_NONE  = 2'd3;

    localparam logic [4:0] DIM_LONG     = 5'd31;
    localparam logic [4:0] DIM_SHORT    = 5'd30;
    localparam logic [4:0] DIM_FEB_LEAP = 5'd29;
    localparam logic [4:0] DIM_FEB      = 5'd28;

    localparam logic [3:0] MONTH_FIRST = 4'd1;
    localparam logic [3:0] MONTH_FEB   = 4'd2;
    localparam logic [3:0] MONTH_LAST  = 4'd12;

endpackage

// File: rtl/calendar_leap.sv
// Leap-year flag and month length for a given month/year.
// CAL_GREGORIAN_EN selects the full Gregorian rule; otherwise every 4th year is leap.
module calendar_leap
    import cal_pkg::*;
#(
    parameter int YEAR_W = 12
) (
    input  logic [3:0]        month_i,
    input  logic [YEAR_W-1:0] year_i,
    output logic              leap_o,
    output logic [4:0]        dim_o
);

    always_comb begin
`ifdef CAL_GREGORIAN_EN
        leap_o = (year_i[1:0] == 2'b00) &&
                 (((year_i % YEAR_W'(100)) != '0) || ((year_i % YEAR_W'(400)) == '0));
`else
        leap_o = (year_i[1:0] == 2'b00);
`endif
    end

    always_comb begin
        case (month_i)
            MONTH_FEB:                 dim_o = leap_o ? DIM_FEB_LEAP : DIM_FEB;
            4'd4, 4'd6, 4'd9, 4'd11:   dim_o = DIM_SHORT;
            default:                   dim_o = DIM_LONG;
        endcase
    end

endmodule

// File: rtl/calendar_date.sv
// Day/month/year counter with tick advance, manual field adjust and day clamp.
// Leap rule chosen by CAL_GREGORIAN_EN inside calendar_leap.
module calendar_date
    import cal_pkg::*;
#(
    parameter int YEAR_W   = 12,
    parameter int YEAR_MIN = 2000,
    parameter int YEAR_MAX = 2099,
    parameter int YEAR_RST = 2000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [1:0]        sel,
    input  logic              inc,
    input  logic              dec,
    output logic [4:0]        day,
    output logic [3:0]        month,
    output logic [YEAR_W-1:0] year,
    output logic              leap,
    output logic [4:0]        dim,
    output logic              carry_out
);

    localparam logic [YEAR_W-1:0] Y_MIN = YEAR_W'(YEAR_MIN);
    localparam logic [YEAR_W-1:0] Y_MAX = YEAR_W'(YEAR_MAX);
    localparam logic [YEAR_W-1:0] Y_RST = YEAR_W'(YEAR_RST);

    logic [4:0]        day_q, day_d;
    logic [3:0]        month_q, month_d;
    logic [YEAR_W-1:0] year_q, year_d;
    logic              carry_q, carry_d;

    logic [3:0]        cand_month;
    logic [YEAR_W-1:0] cand_year;
    logic [4:0]        cand_dim;
    logic              manual_req;

    assign manual_req = (inc ^ dec) && (sel != SEL_NONE);

    calendar_leap #(.YEAR_W(YEAR_W)) u_leap_cur (
        .month_i (month_q),
        .year_i  (year_q),
        .leap_o  (leap),
        .dim_o   (dim)
    );

    // Length of the month a manual month/year change would land in, for the clamp.
    calendar_leap #(.YEAR_W(YEAR_W)) u_leap_cand (
        .month_i (cand_month),
        .year_i  (cand_year),
        .leap_o  (),
        .dim_o   (cand_dim)
    );

    always_comb begin
        cand_month = month_q;
        cand_year  = year_q;
        if (!tick && manual_req) begin
            case (sel)
                SEL_MONTH: begin
                    if (inc) cand_month = (month_q == MONTH_LAST)  ? MONTH_FIRST : month_q + 4'd1;
                    else     cand_month = (month_q == MONTH_FIRST) ? MONTH_LAST  : month_q - 4'd1;
                end
                SEL_YEAR: begin
                    if (inc) cand_year = (year_q == Y_MAX) ? Y_MIN : year_q + YEAR_W'(1);
                    else     cand_year = (year_q == Y_MIN) ? Y_MAX : year_q - YEAR_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        day_d   = day_q;
        month_d = month_q;
        year_d  = year_q;
        carry_d = 1'b0;
        if (tick) begin
            if (day_q < dim) begin
                day_d = day_q + 5'd1;
            end else begin
                day_d = 5'd1;
                if (month_q == MONTH_LAST) begin
                    month_d = MONTH_FIRST;
                    if (year_q == Y_MAX) begin
                        year_d  = Y_MIN;
                        carry_d = 1'b1;
                    end else begin
                        year_d = year_q + YEAR_W'(1);
                    end
                end else begin
                    month_d = month_q + 4'd1;
                end
            end
        end else if (manual_req) begin
            if (sel == SEL_DAY) begin
                if (inc) day_d = (day_q == dim)  ? 5'd1 : day_q + 5'd1;
                else     day_d = (day_q == 5'd1) ? dim  : day_q - 5'd1;
            end else begin
                month_d = cand_month;
                year_d  = cand_year;
                day_d   = (day_q > cand_dim) ? cand_dim : day_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            day_q   <= 5'd1;
            month_q <= MONTH_FIRST;
            year_q  <= Y_RST;
            carry_q <= 1'b0;
        end else begin
            day_q   <= day_d;
            month_q <= month_d;
            year_q  <= year_d;
            carry_q <= carry_d;
        end
    end

    assign day       = day_q;
    assign month     = month_q;
    assign year      = year_q;
    assign carry_out = carry_q;

endmodule

// File: doc/calendar_date.md
CALENDAR_DATE -- requirements
Module: calendar_date

Interface
REQ-001 Parameter YEAR_W, default 12, bit width of the year field.
REQ-002 Parameter YEAR_MIN, default 2000, lowest representable year.
REQ-003 Parameter YEAR_MAX, default 2099, highest representable year; YEAR_MIN < YEAR_MAX < 2^YEAR_W.
REQ-004 Parameter YEAR_RST, default 2000, year loaded on reset; YEAR_MIN <= YEAR_RST <= YEAR_MAX.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 tick  input  1  one-cycle pulse; advances the date by one day (day carry from the hour counter).
REQ-008 sel  input  2  manual field select: 0 = day, 1 = month, 2 = year, 3 = none.
REQ-009 inc  input  1  one-cycle pulse; manual increment of the selected field.
REQ-010 dec  input  1  one-cycle pulse; manual decrement of the selected field.
REQ-011 day  output  5  current day, 1..dim.
REQ-012 month  output  4  current month, 1..12.
REQ-013 year  output  YEAR_W  current year, YEAR_MIN..YEAR_MAX.
REQ-014 leap  output  1  current year is a leap year.
REQ-015 dim  output  5  days in the current month: 31, 30, 29 or 28.
REQ-016 carry_out  output  1  one-cycle pulse on the auto rollover from 31 Dec YEAR_MAX to 1 Jan YEAR_MIN.

Function
REQ-017 leap and dim SHALL be combinational from the registered month and year, with zero latency.
REQ-018 dim SHALL be 31 for months 1, 3, 5, 7, 8, 10 and 12; 30 for months 4, 6, 9 and 11; and for month 2, 29 when leap is 1, otherwise 28.
REQ-019 On tick with day < dim, day SHALL increment by 1.
REQ-020 On tick with day == dim, day SHALL become 1 and month SHALL advance; month 12 SHALL wrap to 1 and advance year.
REQ-021 Year advance from YEAR_MAX by tick SHALL wrap to YEAR_MIN, and carry_out SHALL be 1 in the cycle after that edge.
REQ-022 carry_out SHALL be 0 in every other cycle.
REQ-023 Manual inc on day SHALL wrap dim to 1; manual dec on day SHALL wrap 1 to dim; month and year SHALL be unchanged.
REQ-024 Manual inc and dec on month SHALL wrap 12 <-> 1; year SHALL be unchanged.
REQ-025 Manual inc and dec on year SHALL wrap YEAR_MAX <-> YEAR_MIN; carry_out SHALL stay 0.
REQ-026 After a manual month or year change, day SHALL be clamped in the same edge to min(day, dim of the new month/year).
REQ-027 Example: 31 Mar, month dec -> 29 Feb if leap, else 28 Feb.
REQ-028 Example: 29 Feb 2024, year inc -> 28 Feb 2025.
REQ-029 When tick is active in the same cycle as inc or dec, tick SHALL take priority and the manual request SHALL be dropped.
REQ-030 When inc and dec are both active, or sel == 3, the manual request SHALL cause no change.
REQ-031 No out-of-range day, month or year SHALL ever be produced from in-range state.

Reset
REQ-032 While rst is high, outputs SHALL be day = 1, month = 1, year = YEAR_RST, carry_out = 0, independent of clk.
REQ-033 An assertion of rst during any tick or manual operation SHALL abort it; state SHALL resume from the reset values on the first edge after rst deasserts.

Configuration
REQ-034 With macro CAL_GREGORIAN_EN defined, leap SHALL follow the full Gregorian rule: divisible by 4, except years divisible by 100 unless also divisible by 400.
REQ-035 Without CAL_GREGORIAN_EN, leap SHALL be 1 exactly when year mod 4 == 0.
REQ-036 No other behaviour SHALL depend on CAL_GREGORIAN_EN.

Structure
REQ-037 Package cal_pkg SHALL hold the field-select encoding constants (SEL_DAY, SEL_MONTH, SEL_YEAR, SEL_NONE) and the month-length constants.
REQ-038 Sub-module calendar_leap SHALL compute leap and dim from month and year, including the CAL_GREGORIAN_EN selection.
REQ-039 calendar_date SHALL instantiate calendar_leap twice: once for the current date, once for the candidate date used by the day clamp.

Verification
REQ-040 Reset, then 31 ticks -> 1 Feb YEAR_RST, carry_out never asserted.
REQ-041 Date 28 Feb 2024, tick -> 29 Feb; tick -> 1 Mar. Date 28 Feb 2023, tick -> 1 Mar.
REQ-042 Date 31 Dec 2099, tick -> 1 Jan 2000, carry_out high for exactly one cycle.
REQ-043 Date 31 Jan 2023, sel = 1, inc -> 28 Feb 2023; then sel = 2, dec -> 28 Feb 2022; then sel = 0, inc -> 1 Feb 2022.
REQ-044 tick, inc and dec asserted together on 10 May -> 11 May only. inc and dec together without tick -> no change.
REQ-045 Year 2100 with YEAR_MAX = 2199: leap = 0 with CAL_GREGORIAN_EN, leap = 1 without.
REQ-046 rst asserted mid-sequence between clock edges -> outputs go to reset values immediately.
